lfsr_rng: RTL and testbench
===========================

# lfsr_rng

Parametrised pseudo-random number generator for the board-level display labs: a WIDTH-bit right-shifting LFSR with selectable Fibonacci or Galois feedback. It supports seed loading with zero-lockup protection, free-run or single-step advance, and on-line measurement of the sequence period. The state is also decoded to active-low hex 7-segment digits, so it drives the board displays directly.

## Interface
- WIDTH, 8: state width, legal 4..32.
- FTAPS, 8'h1D: Fibonacci tap mask; bit i set means state[i] feeds the XOR.
- GTAPS, 8'hB8: Galois toggle mask.
- SEED, 8'h01: reset and substitute seed; must be nonzero.
- NDIG (localparam), ceil(WIDTH/4): number of hex digits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  free-run advance, one step per cycle while high.
- step  in  1  single-step request; a rising edge advances once.
- load  in  1  load seed_in this cycle.
- seed_in  in  WIDTH  seed value.
- mode  in  1  feedback mode; 0 = Fibonacci, 1 = Galois.
- random  out  WIDTH  current state.
- valid  out  1  one-cycle pulse; random updated this cycle.
- wrap  out  1  one-cycle pulse; state returned to the start value.
- period  out  WIDTH  last measured period; 0 = not yet measured.
- lockup  out  1  sticky; a zero seed was substituted.
- seg  out  7*NDIG  active-low {g,f,e,d,c,b,a}; digit k shows random[4k+3:4k], zero-padded at the top.

## Operation
- Fibonacci next state: {^(s & FTAPS), s[WIDTH-1:1]}.
- Galois next state: (s >> 1) ^ (s[0] ? GTAPS : 0).
- step_rise = step & ~step_q. step_q is a register, reset to 0.
- advance = en | step_rise.
- Priority per cycle: load, then mode change, then advance.
- load:
  - random <= seed_in, or SEED if seed_in == 0.
  - lockup <= (seed_in == 0).
  - start <= the loaded value; cnt <= 0; valid pulses; period unchanged.
  - A step_rise in the same cycle is consumed and does not advance.
- Mode change (mode != mode_q, with no load):
  - start <= current random; cnt <= 0; the cycle still advances if requested.
  - mode_q updates.
- Advance:
  - random <= next state; valid pulses.
  - If next state == start: wrap pulses, period <= cnt+1, cnt <= 0.
  - Otherwise cnt <= cnt+1. cnt is WIDTH bits; the maximum period 2^WIDTH-1 fits.
- The state never becomes zero, because only nonzero values are loaded and a nonzero XOR LFSR never reaches zero.
- Idle (no load, no advance): all registers hold; valid and wrap are 0.

## Timing
- Reset values:
  - random = SEED.
  - start = SEED.
  - cnt = 0, period = 0.
  - valid = 0, wrap = 0, lockup = 0.
  - step_q = 0, mode_q = 0.
- All outputs except seg are registered. Load and advance are visible one cycle after sampling.
- seg is combinational from random and therefore tracks random in the same cycle.
- valid and wrap are asserted in the same cycle that the new random appears.
- With step held high, exactly one advance occurs; it needs a low cycle to re-arm.
- Reset mid-sequence restores all reset values immediately (asynchronous) and abandons the period measurement.

## Structure
- Shared package lfsr_pkg holds:
  - the mode encoding constants MODE_FIB and MODE_GAL;
  - the default tap masks FTAPS_8 = 8'h1D and GTAPS_8 = 8'hB8;
  - the active-low hex segment lookup constant.
- Sub-module hex7seg (4-bit in, 7-bit active-low out) is instantiated NDIG times in a generate loop.
- The LFSR core, edge detector and period counter live in lfsr_rng itself.

## Test plan
- Reset, then en=1, mode=0, defaults: random = 01, 80, 40, 20, 10, 88 on successive cycles, with valid high on each.
- Hold en=1 from reset, mode=0: wrap pulses exactly once, when random returns to 01 after 255 advances; period = 255 (8'hFF).
- mode=1, load seed 01, then en=1: random = 01, B8, 5C, 2E, 17, B3; after 255 advances wrap pulses and period = 255.
- load=1 with seed_in=0: random = 01 and lockup=1 next cycle. A later load of seed 5A gives random = 5A and clears lockup.
- en=0, step held high for 5 cycles, then low, then high again: exactly two advances. A step rise in the same cycle as load gives the loaded value only.
- random = 8'hA3: seg = {hex7seg(A), hex7seg(3)} = {7'b0001000, 7'b0110000}. Assert rst_n low mid-run: random = 01 and period = 0 asynchronously.

Source files
------------

// File: rtl/lfsr_rng_pkg.sv
// Shared constants for the LFSR random generator: mode encoding, default
// tap masks and the active-low hex 7-segment lookup.
package lfsr_pkg;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  localparam logic [7:0] FTAPS_8 = 8'h1D;
  localparam logic [7:0] GTAPS_8 = 8'hB8;

  // Active-low {g,f,e,d,c,b,a}, indexed by nibble value 0..F
  localparam logic [6:0] SEG_LUT [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/lfsr_rng_hex7seg.sv
// One hex digit decoder: 4-bit nibble to active-low 7-segment pattern.
module hex7seg
  import lfsr_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_LUT[nib];

endmodule

// File: rtl/lfsr_rng.sv
// Right-shifting LFSR with Fibonacci/Galois feedback, seed loading with
// zero-lockup protection, single-step edge detect and period measurement.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] FTAPS = FTAPS_8,
  parameter logic [WIDTH-1:0] GTAPS = GTAPS_8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         step,
  input  logic                         load,
  input  logic [WIDTH-1:0]             seed_in,
  input  logic                         mode,
  output logic [WIDTH-1:0]             random,
  output logic                         valid,
  output logic                         wrap,
  output logic [WIDTH-1:0]             period,
  output logic                         lockup,
  output logic [7*((WIDTH+3)/4)-1:0]   seg
);

  localparam int NDIG = (WIDTH + 3) / 4;

  logic [WIDTH-1:0] random_q, random_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;
  logic             step_q, step_d;
  logic             mode_q, mode_d;

  logic             step_rise, advance, mode_chg;
  logic [WIDTH-1:0] fib_next, gal_next, lfsr_next;
  logic [WIDTH-1:0] start_base, cnt_base;

  always_comb begin
    step_rise  = step & ~step_q;
    advance    = en | step_rise;
    mode_chg   = (mode != mode_q);
    fib_next   = {^(random_q & FTAPS), random_q[WIDTH-1:1]};
    gal_next   = (random_q >> 1) ^ (random_q[0] ? GTAPS : '0);
    lfsr_next  = (mode == MODE_GAL) ? gal_next : fib_next;
    // A mode change restarts the period measurement from the current state
    start_base = mode_chg ? random_q : start_q;
    cnt_base   = mode_chg ? '0 : cnt_q;

    random_d = random_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    lockup_d = lockup_q;
    step_d   = step;
    mode_d   = mode;

    if (load) begin
      random_d = (seed_in == '0) ? SEED : seed_in;
      start_d  = random_d;
      cnt_d    = '0;
      lockup_d = (seed_in == '0);
      valid_d  = 1'b1;
    end else begin
      start_d = start_base;
      cnt_d   = cnt_base;
      if (advance) begin
        random_d = lfsr_next;
        valid_d  = 1'b1;
        if (lfsr_next == start_base) begin
          wrap_d   = 1'b1;
          period_d = cnt_base + WIDTH'(1);
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_base + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random_q <= SEED;
      start_q  <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
      step_q   <= 1'b0;
      mode_q   <= MODE_FIB;
    end else begin
      random_q <= random_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
    end
  end

  assign random = random_q;
  assign valid  = valid_q;
  assign wrap   = wrap_q;
  assign period = period_q;
  assign lockup = lockup_q;

  // Zero-pad the state up to a whole number of hex digits
  logic [4*NDIG-1:0] rnd_pad;
  always_comb begin
    rnd_pad            = '0;
    rnd_pad[WIDTH-1:0] = random_q;
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    hex7seg u_hex (
      .nib   (rnd_pad[4*k +: 4]),
      .seg_n (seg[7*k +: 7])
    );
  end

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng: vector table plus period, seg and async-reset sequences.
module tb_lfsr_rng;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, step = 1'b0, load = 1'b0, mode = 1'b0;
  logic [7:0]  seed_in = 8'h00;
  logic [7:0]  random;
  logic        valid, wrap, lockup;
  logic [7:0]  period;
  logic [13:0] seg;

  int checks = 0;
  int errors = 0;

  lfsr_rng dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .step    (step),
    .load    (load),
    .seed_in (seed_in),
    .mode    (mode),
    .random  (random),
    .valid   (valid),
    .wrap    (wrap),
    .period  (period),
    .lockup  (lockup),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, step, load, mode;
    logic [7:0] seed;
    logic [7:0] exp_rnd;
    logic       exp_vld;
    logic       exp_lock;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic e, s, l, m, input logic [7:0] sd,
                              input logic [7:0] r, input logic v, lk);
    vec_t x;
    x.en = e; x.step = s; x.load = l; x.mode = m; x.seed = sd;
    x.exp_rnd = r; x.exp_vld = v; x.exp_lock = lk;
    vt.push_back(x);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_period(input string tag);
    int wraps, wrap_at;
    logic [7:0] wrap_val;
    wraps = 0; wrap_at = -1; wrap_val = 8'h00;
    for (int i = 1; i <= 260; i++) begin
      tick();
      if (wrap) begin
        wraps++;
        wrap_at  = i;
        wrap_val = random;
      end
    end
    chk({tag, "_wrap_count"}, wraps, 1);
    chk({tag, "_wrap_at"}, wrap_at, 255);
    chk({tag, "_wrap_value"}, wrap_val, 8'h01);
    chk({tag, "_period"}, period, 8'hFF);
  endtask

  initial begin
    //      en step load mode seed  rnd   vld lock
    add(1, 0, 0, 0, 8'h00, 8'h80, 1, 0);
    add(1, 0, 0, 0, 8'h00, 8'h40, 1, 0);
    add(1, 0, 0, 0, 8'h00, 8'h20, 1, 0);
    add(1, 0, 0, 0, 8'h00, 8'h10, 1, 0);
    add(1, 0, 0, 0, 8'h00, 8'h88, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h01, 1, 1);   // zero seed substituted
    add(0, 0, 0, 0, 8'h00, 8'h01, 0, 1);   // idle holds
    add(0, 0, 1, 0, 8'h5A, 8'h5A, 1, 0);
    add(0, 0, 0, 1, 8'h00, 8'h5A, 0, 0);   // mode change without advance
    add(0, 0, 1, 1, 8'h01, 8'h01, 1, 0);
    add(1, 0, 0, 1, 8'h00, 8'hB8, 1, 0);
    add(1, 0, 0, 1, 8'h00, 8'h5C, 1, 0);
    add(1, 0, 0, 1, 8'h00, 8'h2E, 1, 0);
    add(1, 0, 0, 1, 8'h00, 8'h17, 1, 0);
    add(1, 0, 0, 1, 8'h00, 8'hB3, 1, 0);
    add(0, 1, 0, 1, 8'h00, 8'hE1, 1, 0);   // step rise advances once
    add(0, 1, 0, 1, 8'h00, 8'hE1, 0, 0);
    add(0, 1, 0, 1, 8'h00, 8'hE1, 0, 0);
    add(0, 1, 0, 1, 8'h00, 8'hE1, 0, 0);
    add(0, 1, 0, 1, 8'h00, 8'hE1, 0, 0);
    add(0, 0, 0, 1, 8'h00, 8'hE1, 0, 0);
    add(0, 1, 0, 1, 8'h00, 8'hC8, 1, 0);   // re-armed
    add(0, 0, 0, 1, 8'h00, 8'hC8, 0, 0);
    add(0, 1, 1, 1, 8'h3C, 8'h3C, 1, 0);   // step rise consumed by load
    add(0, 1, 0, 1, 8'h00, 8'h3C, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_random", random, 8'h01);
    chk("reset_period", period, 8'h00);
    chk("reset_valid", valid, 1'b0);
    chk("reset_wrap", wrap, 1'b0);
    chk("reset_lockup", lockup, 1'b0);
    chk("reset_seg", seg, {7'b1000000, 7'b1111001});
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vt.size(); i++) begin
      en = vt[i].en; step = vt[i].step; load = vt[i].load;
      mode = vt[i].mode; seed_in = vt[i].seed;
      tick();
      chk($sformatf("vec%0d_random", i), random, vt[i].exp_rnd);
      chk($sformatf("vec%0d_valid", i), valid, vt[i].exp_vld);
      chk($sformatf("vec%0d_lockup", i), lockup, vt[i].exp_lock);
      chk($sformatf("vec%0d_wrap", i), wrap, 1'b0);
    end
    en = 0; step = 0; load = 0; seed_in = 8'h00;

    // Fibonacci full period from reset
    #2 rst_n = 1'b0;
    mode = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    en = 1'b1;
    run_period("fib");

    // Galois full period from seed 01
    en = 1'b0; load = 1'b1; seed_in = 8'h01; mode = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    run_period("gal");

    // Segment decode of A3
    en = 1'b0; load = 1'b1; seed_in = 8'hA3;
    tick();
    load = 1'b0;
    chk("seg_random", random, 8'hA3);
    chk("seg_a3", seg, {7'b0001000, 7'b0110000});

    // Asynchronous reset mid-run
    en = 1'b1;
    repeat (3) tick();
    chk("pre_reset_period", period, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_random", random, 8'h01);
    chk("async_period", period, 8'h00);
    chk("async_valid", valid, 1'b0);
    en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_reset_hold", random, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
